// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmit types and line-level constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_MARK      = 1'b1;
  localparam logic UART_SPACE     = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter; tick on the last cycle of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic div_clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign tick = enable && (r_cnt == LAST);

  // Held at zero while disabled so the first bit after enable is full length.
  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!enable || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART frame sequencer; parity bit exists only with UART_TX_PARITY_EN
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       div_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;
  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic [2:0] r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic       r_tx_serial;
  logic       w_tick;
  logic       w_handshake;

  assign tx_ready    = (r_state == ST_IDLE);
  assign tx_busy     = (r_state != ST_IDLE);
  assign tx_serial   = r_tx_serial;
  assign w_handshake = tx_valid && tx_ready;
  assign tx_done     = (r_state == ST_STOP) && w_tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .div_clk(div_clk),
    .rst_n  (rst_n),
    .enable (tx_busy),
    .tick   (w_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_handshake) begin
      r_parity <= (^tx_data) ^ PARITY_ODD;
    end
  end
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
`endif

  // The line value is registered alongside each transition so it never glitches.
  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_tx_serial <= UART_MARK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_state     <= ST_START;
            r_shift     <= tx_data;
            r_bit_idx   <= '0;
            r_tx_serial <= UART_SPACE;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state     <= ST_DATA;
            r_tx_serial <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_state     <= ST_PARITY;
              r_tx_serial <= r_parity;
`else
              r_state     <= ST_STOP;
              r_tx_serial <= UART_MARK;
`endif
            end else begin
              r_tx_serial <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_state     <= ST_STOP;
            r_tx_serial <= UART_MARK;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            r_state     <= ST_IDLE;
            r_tx_serial <= UART_MARK;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_tx_serial <= UART_MARK;
        end
      endcase
    end
  end

endmodule
